seq_divider_32_bit: RTL and testbench
=====================================

SEQ_DIVIDER_32_BIT -- requirements
Module: seq_divider_32_bit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: in_valid  input  1  operands valid.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: dividend  input  32  numerator, sampled when in_valid&&in_ready.
REQ-007 Port: divisor  input  32  denominator, sampled with dividend.
REQ-008 Port: is_signed  input  1  two's-complement operation when 1, sampled with operands.
REQ-009 Port: out_valid  output  1  results valid.
REQ-010 Port: out_ready  input  1  consumer accepts results.
REQ-011 Port: quotient  output  32  registered quotient.
REQ-012 Port: remainder  output  32  registered remainder.
REQ-013 Port: div_by_zero  output  1  registered flag: captured divisor was zero.

Function
REQ-014 FSM states SHALL be IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on in_valid&&in_ready, latch operands; next state CALC, or DONE if divisor==0.
REQ-016 CALC SHALL run restoring division, one quotient bit per cycle, MSB first, for exactly 32 cycles, using shared 33-bit partial-remainder register and a 32-bit subtract-and-compare.
REQ-017 Each CALC step: R' = {R[31:0], D[msb]}; if R' >= divisor then R = R' - divisor, q bit = 1, else R = R', q bit = 0.
REQ-018 Latency: out_valid SHALL first assert 33 cycles after the accept edge for nonzero divisor, and 1 cycle after it for zero divisor.
REQ-019 DONE: quotient/remainder/div_by_zero held stable until out_valid&&out_ready; then next state IDLE.
REQ-020 New operands SHALL NOT be accepted in CALC or DONE; in_ready first returns high in the cycle after the output handshake.
REQ-021 Divide by zero: quotient = 32'hFFFF_FFFF, remainder = captured dividend, div_by_zero = 1, in signed and unsigned modes.
REQ-022 div_by_zero SHALL be 0 for every nonzero-divisor result.
REQ-023 Unsigned results SHALL satisfy dividend == quotient*divisor + remainder, remainder < divisor.
REQ-024 Signed mode (see Configuration): operate on magnitudes; quotient negated when operand signs differ; remainder takes dividend's sign; quotient rounds toward zero.
REQ-025 Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF SHALL give quotient 32'h8000_0000, remainder 0, div_by_zero 0.
REQ-026 Sign fix-up SHALL occur on the transition into DONE; it SHALL NOT add latency beyond REQ-018.

Reset
REQ-027 rst high SHALL force state IDLE; quotient, remainder, div_by_zero, step counter and internal registers SHALL be 0 on the next edge.
REQ-028 After reset: in_ready = 1, out_valid = 0.
REQ-029 Reset during CALC or DONE SHALL abort the operation silently; no out_valid is produced for it.
REQ-030 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-031 Macro SEQ_DIV_SIGNED_EN: when defined, is_signed selects signed operation per REQ-024/025.
REQ-032 When SEQ_DIV_SIGNED_EN is undefined, is_signed is ignored, sign logic is not built, and all operations are unsigned; latency is unchanged.

Verification
REQ-033 Unsigned 100/7 -> 33 cycles after accept: quotient 14, remainder 2, div_by_zero 0.
REQ-034 Divisor 0, dividend 32'h1234_5678 -> 1 cycle after accept: quotient 32'hFFFF_FFFF, remainder 32'h1234_5678, div_by_zero 1.
REQ-035 SEQ_DIV_SIGNED_EN, is_signed=1: -7/2 -> quotient 32'hFFFF_FFFD (-3), remainder 32'hFFFF_FFFF (-1); 32'h8000_0000/32'hFFFF_FFFF -> quotient 32'h8000_0000, remainder 0.
REQ-036 Backpressure: out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready 0, in_valid ignored; out_ready=1 -> in_ready high next cycle.
REQ-037 rst pulsed at CALC step 15 of 32'hFFFF_FFFF/3 -> IDLE, outputs 0, no out_valid; next 32'hFFFF_FFFF/3 -> quotient 32'h5555_5555, remainder 0.
REQ-038 Without SEQ_DIV_SIGNED_EN: is_signed=1, 32'hFFFF_FFF9/2 -> quotient 32'h7FFF_FFFC, remainder 1.

Source files
------------

// File: rtl/seq_divider_32_bit.sv
// rtl/seq_divider_32_bit.sv - sequential restoring divider, one quotient bit per cycle
// Optional signed support is built when the macro SEQ_DIV_SIGNED_EN is defined;
// otherwise is_signed is ignored and every operation is unsigned.
module seq_divider_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;      // shared partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_quot, neg_rem;
  logic [WIDTH:0]   r_shift, r_next;
  logic [WIDTH+1:0] sub;
  logic             ge;
  logic [WIDTH-1:0] q_next, fin_q, fin_r;

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
  logic a_neg, b_neg;

  // Operand magnitudes and result signs for signed mode
  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag = b_neg ? (~divisor + 1'b1) : divisor;
  end

  assign neg_quot = neg_quot_q;
  assign neg_rem  = neg_rem_q;

  // Sign flags captured with the operands
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign a_mag    = dividend;
  assign b_mag    = divisor;
  assign neg_quot = 1'b0;
  assign neg_rem  = 1'b0;
`endif

  // One restoring step plus the final sign fix-up
  always_comb begin
    r_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    sub     = {1'b0, r_shift} - {2'b00, dvs_q};
    ge      = ~sub[WIDTH+1];
    r_next  = ge ? sub[WIDTH:0] : r_shift;
    q_next  = {dvd_q[WIDTH-2:0], ge};
    fin_q   = neg_quot ? (~q_next + 1'b1) : q_next;
    fin_r   = neg_rem ? (~r_next[WIDTH-1:0] + 1'b1) : r_next[WIDTH-1:0];
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          count_d = '0;
`ifdef SEQ_DIV_SIGNED_EN
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
`endif
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            remo_d  = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            dbz_d   = 1'b0;
          end
        end
      end
      CALC: begin
        rem_d   = r_next;
        dvd_d   = q_next;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          quot_d  = fin_q;
          remo_d  = fin_r;
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32_bit.sv
// tb/tb_seq_divider_32_bit.sv - directed self-checking bench for seq_divider_32_bit
module tb_seq_divider_32_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider_32_bit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er,
                        input logic ez, input int elat, input int hold);
    int lat;
    bit got;
    @(negedge clk);
    check_eq({tag, ".in_ready_before"}, {31'd0, in_ready}, 32'd1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check_eq({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
      if (out_valid) got = 1;
    end
    check_eq({tag, ".latency"}, lat, elat);
    check_eq({tag, ".quotient"}, quotient, eq);
    check_eq({tag, ".remainder"}, remainder, er);
    check_eq({tag, ".div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
    for (int i = 0; i < hold; i++) begin
      dividend = 32'd5;
      divisor  = 32'd1;
      in_valid = 1'b1;
      @(negedge clk);
      check_eq({tag, ".hold_q"}, quotient, eq);
      check_eq({tag, ".hold_r"}, remainder, er);
      check_eq({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      check_eq({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, ".in_ready_after"}, {31'd0, in_ready}, 32'd1);
    check_eq({tag, ".out_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset.in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset.quotient", quotient, 32'd0);
    check_eq("reset.remainder", remainder, 32'd0);
    check_eq("reset.div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 0);
    run_op("dbz", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1, 0);
    run_op("u_max_3", 32'hFFFF_FFFF, 32'd3, 1'b0, 32'h5555_5555, 32'd0, 1'b0, 33, 0);
    run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 0);
    run_op("u_small", 32'd5, 32'd10, 1'b0, 32'd0, 32'd5, 1'b0, 33, 0);
    run_op("u_zero_num", 32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 33, 0);
    run_op("u_max_div", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'hFFFF_FFFE, 1'b0, 33, 0);
    run_op("backpressure", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 10);
    run_op("dbz_signed", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1, 0);
`ifdef SEQ_DIV_SIGNED_EN
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, 0);
    run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 0);
`else
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, 0);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 33, 0);
`endif

    // Abort an operation midway through CALC with a reset pulse
    @(negedge clk);
    dividend  = 32'hFFFF_FFFF;
    divisor   = 32'd3;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort.in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("abort.out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("abort.quotient", quotient, 32'd0);
    check_eq("abort.remainder", remainder, 32'd0);
    check_eq("abort.div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst  = 1'b0;
    seen = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check_eq("abort.no_out_valid", {31'd0, seen}, 32'd0);
    run_op("after_abort", 32'hFFFF_FFFF, 32'd3, 1'b0, 32'h5555_5555, 32'd0, 1'b0, 33, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
